// File: rtl/sdram_responder.sv
// SDR SDRAM device-side responder.
// Decodes RAS#/CAS#/WE# commands, tracks per-bank open rows, stores data in
// byte-lane block RAMs and returns read data after the programmed CAS latency.
// Protocol timing is checked; the first violation is latched in err_code.
//
// Spacing counters are cleared at the command edge and count the idle edges
// that follow, so a command k edges after ACT sees a count of k-1. A RD on the
// edge right after ACT therefore sees 0 and violates T_RCD=1.
module sdram_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ROW_WIDTH  = 11,
  parameter int COL_WIDTH  = 8,
  parameter int BANK_WIDTH = 2,
  parameter int MEM_AW     = 10,
  parameter int T_RCD      = 1,
  parameter int T_RC       = 4,
  parameter int T_WR       = 2,
  parameter int T_RP       = 1,
  parameter int T_MRD      = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  inout  wire  [DATA_WIDTH-1:0]   sdram_dq,
  input  logic [ROW_WIDTH-1:0]    sdram_a,
  input  logic [BANK_WIDTH-1:0]   sdram_ba,
  input  logic                    sdram_ncs,
  input  logic                    sdram_nras,
  input  logic                    sdram_ncas,
  input  logic                    sdram_nwe,
  input  logic                    sdram_cke,
  input  logic [DATA_WIDTH/8-1:0] sdram_dqm,
  output logic                    init_done,
  output logic [2:0]              cas_lat,
  output logic                    err,
  output logic [3:0]              err_code,
  output logic [15:0]             ref_count
);

  localparam int NUM_BANKS = 1 << BANK_WIDTH;
  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int MEM_DEPTH = 1 << MEM_AW;

  localparam logic [3:0] CNT_MAX  = 4'hF;
  localparam logic [3:0] RCD_MIN  = 4'(T_RCD);
  localparam logic [3:0] RC_MIN   = 4'(T_RC);
  localparam logic [3:0] WRP_MIN  = 4'(T_WR + T_RP);
  localparam logic [3:0] MRD_LAST = 4'(T_MRD - 1);

  localparam logic [3:0] ERR_NONE       = 4'd0;
  localparam logic [3:0] ERR_INIT       = 4'd1;
  localparam logic [3:0] ERR_NOT_ACTIVE = 4'd2;
  localparam logic [3:0] ERR_NOT_IDLE   = 4'd3;
  localparam logic [3:0] ERR_RCD        = 4'd4;
  localparam logic [3:0] ERR_RC         = 4'd5;
  localparam logic [3:0] ERR_BANKS_OPEN = 4'd6;
  localparam logic [3:0] ERR_MODE       = 4'd7;
  localparam logic [3:0] ERR_DQ_BUSY    = 4'd8;

  typedef enum logic [2:0] {
    CMD_MRS = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_NOP = 3'b111
  } cmd_t;

  typedef enum logic [2:0] {
    ST_WAIT_PRE,
    ST_WAIT_REF1,
    ST_WAIT_REF2,
    ST_WAIT_MRS,
    ST_MRD_WAIT,
    ST_READY
  } init_state_t;

  cmd_t                  cmd;
  init_state_t           state_reg, state_next;
  logic [3:0]            mrd_cnt_reg;

  logic [NUM_BANKS-1:0]  bank_active;
  logic [ROW_WIDTH-1:0]  bank_row       [NUM_BANKS];
  logic [3:0]            bank_since_act [NUM_BANKS];
  logic [3:0]            bank_since_wr  [NUM_BANKS];
  logic [3:0]            since_ref_reg;

  logic                  sel_active;
  logic [3:0]            sel_since_act;
  logic [3:0]            sel_since_wr;
  logic                  all_idle;
  logic                  auto_pre;
  logic                  mrs_ok;

  logic                  do_act, do_rd, do_wr, do_pre, do_ref, do_mrs;
  logic [3:0]            cmd_err_code;
  logic                  cmd_err;

  logic [2:0]            cas_lat_reg;
  logic                  err_reg;
  logic [3:0]            err_code_reg;
  logic [15:0]           ref_count_reg;

  logic [MEM_AW-1:0]     mem_idx;
  logic [DATA_WIDTH-1:0] dq_in;
  logic [DATA_WIDTH-1:0] rd0_data;
  logic                  rd0_valid_reg;
  logic                  rd0_long_reg;
  logic [NUM_BYTES-1:0]  rd0_mask_reg;
  logic                  rd1_valid_reg;
  logic [DATA_WIDTH-1:0] rd1_data_reg;
  logic                  dq_oe_reg;
  logic [DATA_WIDTH-1:0] dq_out_reg;

  assign sel_active    = bank_active[sdram_ba];
  assign sel_since_act = bank_since_act[sdram_ba];
  assign sel_since_wr  = bank_since_wr[sdram_ba];
  assign all_idle      = ~|bank_active;
  assign auto_pre      = sdram_a[10];
  assign mrs_ok        = (sdram_a[2:0] == 3'b000) &&
                         ((sdram_a[6:4] == 3'd2) || (sdram_a[6:4] == 3'd3));
  assign mem_idx       = MEM_AW'({sdram_ba, bank_row[sdram_ba], sdram_a[COL_WIDTH-1:0]});
  assign dq_in         = sdram_dq;
  assign sdram_dq      = dq_oe_reg ? dq_out_reg : {DATA_WIDTH{1'bz}};
  assign cmd_err       = |cmd_err_code;

  assign init_done = (state_reg == ST_READY);
  assign cas_lat   = cas_lat_reg;
  assign err       = err_reg;
  assign err_code  = err_code_reg;
  assign ref_count = ref_count_reg;

  // Command decode; deselect, clock-disable, burst stop and reset all look like NOP.
  always_comb begin
    cmd = CMD_NOP;
    if (resetn && !sdram_ncs && sdram_cke) begin
      unique case ({sdram_nras, sdram_ncas, sdram_nwe})
        3'b000:  cmd = CMD_MRS;
        3'b001:  cmd = CMD_REF;
        3'b010:  cmd = CMD_PRE;
        3'b011:  cmd = CMD_ACT;
        3'b100:  cmd = CMD_WR;
        3'b101:  cmd = CMD_RD;
        default: cmd = CMD_NOP;
      endcase
    end
  end

  // Init FSM next state plus command legality; an illegal command raises a code and does nothing else.
  always_comb begin
    state_next   = state_reg;
    do_act       = 1'b0;
    do_rd        = 1'b0;
    do_wr        = 1'b0;
    do_pre       = 1'b0;
    do_ref       = 1'b0;
    do_mrs       = 1'b0;
    cmd_err_code = ERR_NONE;
    unique case (state_reg)
      ST_WAIT_PRE: begin
        if (cmd == CMD_PRE && auto_pre) begin
          state_next = ST_WAIT_REF1;
          do_pre     = 1'b1;
        end else if (cmd != CMD_NOP) begin
          cmd_err_code = ERR_INIT;
        end
      end
      ST_WAIT_REF1: begin
        if (cmd == CMD_REF)      state_next   = ST_WAIT_REF2;
        else if (cmd != CMD_NOP) cmd_err_code = ERR_INIT;
      end
      ST_WAIT_REF2: begin
        if (cmd == CMD_REF)      state_next   = ST_WAIT_MRS;
        else if (cmd != CMD_NOP) cmd_err_code = ERR_INIT;
      end
      ST_WAIT_MRS: begin
        if (cmd == CMD_MRS) begin
          if (mrs_ok) begin
            state_next = ST_MRD_WAIT;
            do_mrs     = 1'b1;
          end else begin
            cmd_err_code = ERR_MODE;
          end
        end else if (cmd != CMD_NOP) begin
          cmd_err_code = ERR_INIT;
        end
      end
      ST_MRD_WAIT: begin
        if (cmd != CMD_NOP) cmd_err_code = ERR_INIT;
        if (mrd_cnt_reg == MRD_LAST) state_next = ST_READY;
      end
      ST_READY: begin
        unique case (cmd)
          CMD_MRS: begin
            if (!all_idle)    cmd_err_code = ERR_BANKS_OPEN;
            else if (!mrs_ok) cmd_err_code = ERR_MODE;
            else              do_mrs       = 1'b1;
          end
          CMD_REF: begin
            if (!all_idle)                  cmd_err_code = ERR_BANKS_OPEN;
            else if (since_ref_reg < RC_MIN) cmd_err_code = ERR_RC;
            else                            do_ref       = 1'b1;
          end
          CMD_PRE: do_pre = 1'b1;
          CMD_ACT: begin
            if (sel_active)
              cmd_err_code = ERR_NOT_IDLE;
            else if (sel_since_act < RC_MIN || sel_since_wr < WRP_MIN)
              cmd_err_code = ERR_RC;
            else
              do_act = 1'b1;
          end
          CMD_RD, CMD_WR: begin
            if (!sel_active)                 cmd_err_code = ERR_NOT_ACTIVE;
            else if (sel_since_act < RCD_MIN) cmd_err_code = ERR_RCD;
            else if (cmd == CMD_WR && dq_oe_reg) cmd_err_code = ERR_DQ_BUSY;
            else if (cmd == CMD_WR)          do_wr        = 1'b1;
            else                             do_rd        = 1'b1;
          end
          default: ;
        endcase
      end
      default: state_next = ST_WAIT_PRE;
    endcase
  end

  // Init FSM state register and mode-register settle counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg   <= ST_WAIT_PRE;
      mrd_cnt_reg <= 4'd0;
    end else begin
      state_reg <= state_next;
      if (state_reg != ST_MRD_WAIT) mrd_cnt_reg <= 4'd0;
      else                          mrd_cnt_reg <= mrd_cnt_reg + 4'd1;
    end
  end

  genvar gi;

  // Per-bank row state and saturating spacing counters.
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      logic                 bank_hit;
      logic                 active_reg;
      logic [ROW_WIDTH-1:0] row_reg;
      logic [3:0]           since_act_reg;
      logic [3:0]           since_wr_reg;

      assign bank_hit           = (sdram_ba == BANK_WIDTH'(gi));
      assign bank_active[gi]    = active_reg;
      assign bank_row[gi]       = row_reg;
      assign bank_since_act[gi] = since_act_reg;
      assign bank_since_wr[gi]  = since_wr_reg;

      // Open/close the bank and restart its counters on ACT and auto-precharged WR.
      always_ff @(posedge clk) begin
        if (!resetn) begin
          active_reg    <= 1'b0;
          row_reg       <= '0;
          since_act_reg <= CNT_MAX;
          since_wr_reg  <= CNT_MAX;
        end else begin
          if (since_act_reg != CNT_MAX) since_act_reg <= since_act_reg + 4'd1;
          if (since_wr_reg != CNT_MAX)  since_wr_reg  <= since_wr_reg + 4'd1;
          if (do_act && bank_hit) begin
            active_reg    <= 1'b1;
            row_reg       <= sdram_a;
            since_act_reg <= 4'd0;
          end
          if ((do_rd || do_wr) && bank_hit && auto_pre) active_reg   <= 1'b0;
          if (do_wr && bank_hit && auto_pre)            since_wr_reg <= 4'd0;
          if (do_pre && (auto_pre || bank_hit))         active_reg   <= 1'b0;
        end
      end
    end
  endgenerate

  // Global ACT/REF spacing, mode register, refresh count and sticky first-error capture.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      since_ref_reg <= CNT_MAX;
      cas_lat_reg   <= 3'd2;
      err_reg       <= 1'b0;
      err_code_reg  <= ERR_NONE;
      ref_count_reg <= 16'd0;
    end else begin
      if (since_ref_reg != CNT_MAX) since_ref_reg <= since_ref_reg + 4'd1;
      if (do_act || do_ref)         since_ref_reg <= 4'd0;
      if (do_ref)                   ref_count_reg <= ref_count_reg + 16'd1;
      if (do_mrs)                   cas_lat_reg   <= sdram_a[6:4];
      if (cmd_err) begin
        err_reg <= 1'b1;
        if (!err_reg) err_code_reg <= cmd_err_code;
      end
    end
  end

  // Byte-lane storage: masked write and registered read taken at the RD edge.
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
      logic [7:0] lane_mem [MEM_DEPTH];
      logic [7:0] lane_q_reg;

      // Array write on unmasked WR bytes, array read on every accepted RD.
      always_ff @(posedge clk) begin
        if (do_wr && !sdram_dqm[gi]) lane_mem[mem_idx] <= dq_in[gi*8 +: 8];
        if (do_rd)                   lane_q_reg        <= lane_mem[mem_idx];
      end

      assign rd0_data[gi*8 +: 8] = rd0_mask_reg[gi] ? 8'h00 : lane_q_reg;
    end
  endgenerate

  // Read latency pipe: CL2 drives from stage 0, CL3 takes one extra stage.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd0_valid_reg <= 1'b0;
      rd0_long_reg  <= 1'b0;
      rd0_mask_reg  <= '0;
      rd1_valid_reg <= 1'b0;
      rd1_data_reg  <= '0;
      dq_oe_reg     <= 1'b0;
      dq_out_reg    <= '0;
    end else begin
      rd0_valid_reg <= do_rd;
      rd0_long_reg  <= (cas_lat_reg == 3'd3);
      if (do_rd) rd0_mask_reg <= sdram_dqm;
      rd1_valid_reg <= rd0_valid_reg && rd0_long_reg;
      rd1_data_reg  <= rd0_data;
      dq_oe_reg     <= (rd0_valid_reg && !rd0_long_reg) || rd1_valid_reg;
      dq_out_reg    <= rd1_valid_reg ? rd1_data_reg : rd0_data;
    end
  end

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: init, write/read with masks, CAS 2/3
// latency, protocol error codes and reset during a pending read.
module tb_sdram_responder;

  localparam logic [31:0] KEEP = 32'hA5C3_0F69;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  wire  [31:0] dq;
  logic [31:0] tb_dq = 32'h0;
  logic        tb_dq_en = 1'b0;
  logic [10:0] a = '0;
  logic [1:0]  ba = '0;
  logic        ncs = 1'b1, nras = 1'b1, ncas = 1'b1, nwe = 1'b1, cke = 1'b1;
  logic [3:0]  dqm = '0;
  logic        init_done;
  logic [2:0]  cas_lat;
  logic        err;
  logic [3:0]  err_code;
  logic [15:0] ref_count;

  int checks = 0;
  int errors = 0;

  assign dq = tb_dq_en ? tb_dq : 32'hzzzz_zzzz;

  always #5 clk = ~clk;

  sdram_responder dut (
    .clk        (clk),
    .resetn     (resetn),
    .sdram_dq   (dq),
    .sdram_a    (a),
    .sdram_ba   (ba),
    .sdram_ncs  (ncs),
    .sdram_nras (nras),
    .sdram_ncas (ncas),
    .sdram_nwe  (nwe),
    .sdram_cke  (cke),
    .sdram_dqm  (dqm),
    .init_done  (init_done),
    .cas_lat    (cas_lat),
    .err        (err),
    .err_code   (err_code),
    .ref_count  (ref_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // DUT released the bus if our keeper pattern reads back unchanged.
  task automatic check_z(input string tag);
    tb_dq    = KEEP;
    tb_dq_en = 1'b1;
    #1;
    check(tag, dq, KEEP);
    tb_dq_en = 1'b0;
  endtask

  task automatic issue(input logic [2:0] c, input logic [1:0] b, input logic [10:0] addr,
                       input logic [3:0] m, input logic [31:0] wd, input logic drv);
    ncs = 1'b0;
    {nras, ncas, nwe} = c;
    ba = b;
    a = addr;
    dqm = m;
    tb_dq = wd;
    tb_dq_en = drv;
    tick();
    ncs = 1'b1;
    {nras, ncas, nwe} = 3'b111;
    tb_dq_en = 1'b0;
  endtask

  task automatic nop(input int n);
    repeat (n) tick();
  endtask

  task automatic act(input logic [1:0] b, input logic [10:0] row);
    issue(3'b011, b, row, 4'h0, 32'h0, 1'b0);
  endtask

  task automatic wr(input logic [1:0] b, input logic [7:0] col, input logic ap,
                    input logic [31:0] d, input logic [3:0] m);
    issue(3'b100, b, {ap, 2'b00, col}, m, d, 1'b1);
  endtask

  task automatic rd(input logic [1:0] b, input logic [7:0] col, input logic ap, input logic [3:0] m);
    issue(3'b101, b, {ap, 2'b00, col}, m, 32'h0, 1'b0);
  endtask

  task automatic pre_all();
    issue(3'b010, 2'd0, 11'h400, 4'h0, 32'h0, 1'b0);
  endtask

  task automatic refresh();
    issue(3'b001, 2'd0, 11'h000, 4'h0, 32'h0, 1'b0);
  endtask

  task automatic mrs(input logic [10:0] mode);
    issue(3'b000, 2'd0, mode, 4'h0, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic init_seq(input string tag);
    pre_all();
    refresh();
    refresh();
    mrs(11'h020);
    nop(1);
    check({tag, "_mrd_wait"}, 32'(init_done), 32'd0);
    nop(1);
    check({tag, "_init_done"}, 32'(init_done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    resetn = 1'b0;
    tick();
    tick();
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_cas_lat", 32'(cas_lat), 32'd2);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_ref_count", 32'(ref_count), 32'd0);
    check_z("rst_dq_z");
    resetn = 1'b1;

    // Init sequence
    init_seq("init1");
    check("init1_cas", 32'(cas_lat), 32'd2);
    check("init1_err", 32'(err), 32'd0);
    refresh();
    check("ref_count_1", 32'(ref_count), 32'd1);

    // Write with auto-precharge, re-open, read back at CL2
    act(2'd1, 11'd5);
    nop(1);
    wr(2'd1, 8'd7, 1'b1, 32'hDEADBEEF, 4'h0);
    nop(4);
    act(2'd1, 11'd5);
    nop(1);
    rd(2'd1, 8'd7, 1'b0, 4'h0);
    check_z("cl2_edge1_z");
    nop(1);
    check("cl2_data", dq, 32'hDEADBEEF);
    nop(1);
    check_z("cl2_after_z");
    check("cl2_err", 32'(err), 32'd0);

    // Byte-masked write merge
    wr(2'd1, 8'd8, 1'b0, 32'h11223344, 4'h0);
    wr(2'd1, 8'd8, 1'b0, 32'hAABBCCDD, 4'b0101);
    rd(2'd1, 8'd8, 1'b0, 4'h0);
    nop(1);
    check("mask_merge", dq, 32'hAA22CC44);

    // Back-to-back reads, second with read mask
    nop(1);
    rd(2'd1, 8'd7, 1'b0, 4'h0);
    rd(2'd1, 8'd8, 1'b0, 4'b0011);
    check("b2b_first", dq, 32'hDEADBEEF);
    nop(1);
    check("b2b_second_masked", dq, 32'hAA220000);
    nop(1);
    check_z("b2b_after_z");

    // CAS latency 3
    pre_all();
    mrs(11'h030);
    check("mrs_cl3", 32'(cas_lat), 32'd3);
    act(2'd1, 11'd5);
    nop(1);
    rd(2'd1, 8'd7, 1'b0, 4'h0);
    check_z("cl3_edge1_z");
    nop(1);
    check_z("cl3_edge2_z");
    nop(1);
    check("cl3_data", dq, 32'hDEADBEEF);
    nop(1);
    check_z("cl3_after_z");
    pre_all();
    mrs(11'h020);
    check("mrs_cl2", 32'(cas_lat), 32'd2);
    check("pre_err_none", 32'(err), 32'd0);

    // RD zero cycles after ACT
    act(2'd2, 11'd0);
    rd(2'd2, 8'd0, 1'b0, 4'h0);
    check("rcd_err", 32'(err), 32'd1);
    check("rcd_code", 32'(err_code), 32'd4);
    check_z("rcd_no_drive1");
    nop(1);
    check_z("rcd_no_drive2");
    refresh();
    check("ref_open_code_kept", 32'(err_code), 32'd4);
    check("ref_open_no_count", 32'(ref_count), 32'd1);

    // Reset while read data pending
    act(2'd1, 11'd5);
    nop(1);
    rd(2'd1, 8'd8, 1'b0, 4'h0);
    resetn = 1'b0;
    tick();
    check_z("rst_pending_z");
    check("rst_pending_init_done", 32'(init_done), 32'd0);
    check("rst_pending_err", 32'(err), 32'd0);
    resetn = 1'b1;
    init_seq("init2");
    act(2'd1, 11'd5);
    nop(1);
    rd(2'd1, 8'd8, 1'b0, 4'h0);
    nop(1);
    check("retained_data", dq, 32'hAA22CC44);
    nop(1);

    // ACT on an open bank
    act(2'd1, 11'd5);
    check("act_open_code", 32'(err_code), 32'd3);

    // RD before init
    do_reset();
    rd(2'd0, 8'd0, 1'b0, 4'h0);
    check("pre_init_code", 32'(err_code), 32'd1);
    check_z("pre_init_no_drive");

    // Illegal mode during init, then a legal one
    do_reset();
    pre_all();
    refresh();
    refresh();
    mrs(11'h010);
    check("bad_mrs_code", 32'(err_code), 32'd7);
    check("bad_mrs_cas", 32'(cas_lat), 32'd2);
    mrs(11'h030);
    nop(2);
    check("init3_done", 32'(init_done), 32'd1);
    check("init3_cas", 32'(cas_lat), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
